// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one synchronous memory port among NUM_CH requesters.
// Optional: define ARB_PRIO0_EN to give ch0 (data port) absolute priority over the round-robin.
module mem_port_arbiter_lane #(
  parameter int PW  = 1,
  parameter int IDX = 0
) (
  input  logic [PW-1:0] rr_ptr,
  input  logic          req,
  output logic          req_hi
);
  // Channels at or above the pointer form the preferred half of the rotation.
  assign req_hi = req && (PW'(IDX) >= rr_ptr);
endmodule

module mem_port_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        we,
  input  logic [2*NUM_CH-1:0]      size,
  input  logic [NUM_CH-1:0]        sgn,
  input  logic [ADDR_W*NUM_CH-1:0] addr,
  input  logic [DATA_W*NUM_CH-1:0] wdata,
  output logic [NUM_CH-1:0]        gnt,
  output logic [NUM_CH-1:0]        rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [1:0]               mem_size,
  output logic                     mem_sgn,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PW-1:0] LAST = PW'(NUM_CH - 1);

  logic [NUM_CH-1:0][1:0]        size_v;
  logic [NUM_CH-1:0][ADDR_W-1:0] addr_v;
  logic [NUM_CH-1:0][DATA_W-1:0] wdata_v;
  assign size_v  = size;
  assign addr_v  = addr;
  assign wdata_v = wdata;

  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     win;
  logic              any;
  logic              adv;
  logic [NUM_CH-1:0] req_hi;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    mem_port_arbiter_lane #(.PW(PW), .IDX(i)) u_lane (
      .rr_ptr (rr_ptr),
      .req    (req[i]),
      .req_hi (req_hi[i])
    );
  end

  // Lowest requester at/above rr_ptr wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (req[i]) begin
        win = PW'(i);
        any = 1'b1;
      end
    if (|req_hi)
      for (int i = NUM_CH - 1; i >= 0; i--)
        if (req_hi[i]) win = PW'(i);
`ifdef ARB_PRIO0_EN
    if (req[0]) win = '0;
`endif
    if (rst) any = 1'b0;
    gnt = '0;
    if (any) gnt[win] = 1'b1;
  end

`ifdef ARB_PRIO0_EN
  assign adv = (win != '0);
`else
  assign adv = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst)
      rr_ptr <= '0;
    else if (any && adv)
      rr_ptr <= (win == LAST) ? '0 : win + PW'(1);

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_size  <= '0;
      mem_sgn   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= any;
      if (any) begin
        mem_we    <= we[win];
        mem_size  <= size_v[win];
        mem_sgn   <= sgn[win];
        mem_addr  <= addr_v[win];
        mem_wdata <= wdata_v[win];
      end
    end

  // Read tags: stage s is live in cycle grant+1+s; rdata is captured one stage before rvalid.
  logic [MEM_LAT:0]              vld_pipe;
  logic [MEM_LAT:0][NUM_CH-1:0]  ch_pipe;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld_pipe <= '0;
      ch_pipe  <= '0;
      rdata    <= '0;
    end else begin
      vld_pipe[0] <= any && !we[win];
      ch_pipe[0]  <= gnt;
      for (int s = 1; s <= MEM_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        ch_pipe[s]  <= ch_pipe[s-1];
      end
      if (vld_pipe[MEM_LAT-1]) rdata <= mem_rdata;
    end

  assign rvalid = vld_pipe[MEM_LAT] ? ch_pipe[MEM_LAT] : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: 2-channel/latency-1 and 4-channel/latency-2 arbiters against small memory models.
module tb_mem_port_arbiter;
  typedef struct {
    int          due;
    logic [7:0]  ch;
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [7:0]  addr;
    logic [31:0] data;
  } ent_t;

`ifdef ARB_PRIO0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 2-channel, MEM_LAT = 1
  logic [1:0]  req_a, we_a, sgn_a, gnt_a, rvalid_a;
  logic [3:0]  size_a;
  logic [15:0] addr_a;
  logic [63:0] wdata_a;
  logic [31:0] rdata_a, mem_wdata_a, mem_rdata_a;
  logic        mem_en_a, mem_we_a, mem_sgn_a;
  logic [1:0]  mem_size_a;
  logic [7:0]  mem_addr_a;

  // 4-channel, MEM_LAT = 2
  logic [3:0]   req_b, we_b, sgn_b, gnt_b, rvalid_b;
  logic [7:0]   size_b;
  logic [31:0]  addr_b;
  logic [127:0] wdata_b;
  logic [31:0]  rdata_b, mem_wdata_b, mem_rdata_b;
  logic         mem_en_b, mem_we_b, mem_sgn_b;
  logic [1:0]   mem_size_b;
  logic [7:0]   mem_addr_b;

  mem_port_arbiter #(.NUM_CH(2), .ADDR_W(8), .DATA_W(32), .MEM_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .we(we_a), .size(size_a), .sgn(sgn_a),
    .addr(addr_a), .wdata(wdata_a), .gnt(gnt_a), .rvalid(rvalid_a), .rdata(rdata_a),
    .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_size(mem_size_a), .mem_sgn(mem_sgn_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a));

  mem_port_arbiter #(.NUM_CH(4), .ADDR_W(8), .DATA_W(32), .MEM_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .we(we_b), .size(size_b), .sgn(sgn_b),
    .addr(addr_b), .wdata(wdata_b), .gnt(gnt_b), .rvalid(rvalid_b), .rdata(rdata_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_size(mem_size_b), .mem_sgn(mem_sgn_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b));

  // Memory A: combinational read of the registered address, write at the command edge.
  logic [31:0] mem_a [256];
  always @(posedge clk)
    if (rst) for (int i = 0; i < 256; i++) mem_a[i] <= 32'hC0DE0000 | 32'(i);
    else if (mem_en_a && mem_we_a) mem_a[mem_addr_a] <= mem_wdata_a;
  assign mem_rdata_a = mem_a[mem_addr_a];

  // Memory B: read-only pattern with one register stage.
  always @(posedge clk) mem_rdata_b <= 32'hC0DE0000 | 32'(mem_addr_b);

  ent_t qg_a[$], qm_a[$], qr_a[$], qg_b[$], qr_b[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [1:0] r, input logic [1:0] w, input logic [7:0] a0,
                         input logic [7:0] a1, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [1:0] eg, input logic [31:0] erd, input bit live);
    int g;
    req_a = r; we_a = w; addr_a = {a1, a0}; wdata_a = {d1, d0};
    g = eg[1] ? 1 : 0;
    if (eg != 2'b00) begin
      qg_a.push_back('{cyc, 8'(eg), 1'b0, 2'b00, 1'b0, 8'h00, 32'h0});
      if (live) begin
        qm_a.push_back('{cyc + 1, 8'(eg), w[g], g ? 2'b01 : 2'b10, g == 1, g ? a1 : a0, g ? d1 : d0});
        if (!w[g]) qr_a.push_back('{cyc + 2, 8'(eg), 1'b0, 2'b00, 1'b0, 8'h00, erd});
      end
    end
  endtask

  task automatic drive_b(input logic [3:0] r, input logic [3:0] eg, input logic [31:0] erd);
    req_b = r;
    if (eg != 4'h0) begin
      qg_b.push_back('{cyc, 8'(eg), 1'b0, 2'b00, 1'b0, 8'h00, 32'h0});
      qr_b.push_back('{cyc + 3, 8'(eg), 1'b0, 2'b00, 1'b0, 8'h00, erd});
    end
  endtask

  // Monitor: pop whenever the DUT presents an output; flag heads that fall due unserved.
  always @(negedge clk) begin
    ent_t e;
    if (gnt_a != '0) begin
      if (qg_a.size() == 0) check("gnt_a_extra", 64'(gnt_a), 64'(0));
      else begin e = qg_a.pop_front(); check("gnt_a", {32'(cyc), 32'(gnt_a)}, {32'(e.due), 32'(e.ch)}); end
    end else if (qg_a.size() != 0 && qg_a[0].due <= cyc) begin
      e = qg_a.pop_front(); check("gnt_a_missing", {32'(cyc), 32'(gnt_a)}, {32'(e.due), 32'(e.ch)});
    end
    if (mem_en_a) begin
      if (qm_a.size() == 0) check("mem_a_extra", 64'(mem_en_a), 64'(0));
      else begin
        e = qm_a.pop_front();
        check("mem_a_cycle", 64'(cyc), 64'(e.due));
        check("mem_a_cmd", {20'h0, mem_we_a, mem_size_a, mem_sgn_a, mem_addr_a, mem_wdata_a},
                           {20'h0, e.we, e.sz, e.sg, e.addr, e.data});
      end
    end else if (qm_a.size() != 0 && qm_a[0].due <= cyc) begin
      e = qm_a.pop_front(); check("mem_a_missing", {32'(cyc), 32'(mem_en_a)}, {32'(e.due), 32'(1)});
    end
    if (rvalid_a != '0) begin
      if (qr_a.size() == 0) check("rvalid_a_extra", 64'(rvalid_a), 64'(0));
      else begin
        e = qr_a.pop_front();
        check("rvalid_a", {32'(cyc), 32'(rvalid_a)}, {32'(e.due), 32'(e.ch)});
        check("rdata_a", 64'(rdata_a), 64'(e.data));
      end
    end else if (qr_a.size() != 0 && qr_a[0].due <= cyc) begin
      e = qr_a.pop_front(); check("rvalid_a_missing", {32'(cyc), 32'(rvalid_a)}, {32'(e.due), 32'(e.ch)});
    end
    if (gnt_b != '0) begin
      if (qg_b.size() == 0) check("gnt_b_extra", 64'(gnt_b), 64'(0));
      else begin e = qg_b.pop_front(); check("gnt_b", {32'(cyc), 32'(gnt_b)}, {32'(e.due), 32'(e.ch)}); end
    end else if (qg_b.size() != 0 && qg_b[0].due <= cyc) begin
      e = qg_b.pop_front(); check("gnt_b_missing", {32'(cyc), 32'(gnt_b)}, {32'(e.due), 32'(e.ch)});
    end
    if (rvalid_b != '0) begin
      if (qr_b.size() == 0) check("rvalid_b_extra", 64'(rvalid_b), 64'(0));
      else begin
        e = qr_b.pop_front();
        check("rvalid_b", {32'(cyc), 32'(rvalid_b)}, {32'(e.due), 32'(e.ch)});
        check("rdata_b", 64'(rdata_b), 64'(e.data));
      end
    end else if (qr_b.size() != 0 && qr_b[0].due <= cyc) begin
      e = qr_b.pop_front(); check("rvalid_b_missing", {32'(cyc), 32'(rvalid_b)}, {32'(e.due), 32'(e.ch)});
    end
  end

  initial begin
    rst = 1'b1;
    req_a = 2'b11; we_a = '0; size_a = 4'b0110; sgn_a = 2'b10; addr_a = '0; wdata_a = '0;
    req_b = 4'hF; we_b = '0; size_b = 8'hAA; sgn_b = '0; wdata_b = '0;
    addr_b = {8'h53, 8'h52, 8'h51, 8'h50};
    tick; tick;
    @(negedge clk);
    check("rst_gnt_a", 64'(gnt_a), 64'(0));
    check("rst_mem_en_a", 64'(mem_en_a), 64'(0));
    check("rst_rvalid_a", 64'(rvalid_a), 64'(0));
    check("rst_rdata_a", 64'(rdata_a), 64'(0));
    check("rst_gnt_b", 64'(gnt_b), 64'(0));

    // Contention with req held on both channels
    tick; rst = 1'b0; req_b = '0;
    drive_a(2'b11, 2'b00, 8'h01, 8'h02, 0, 0, 2'b01, 32'hC0DE0001, 1);
    tick; drive_a(2'b11, 2'b00, 8'h01, 8'h02, 0, 0, PRIO ? 2'b01 : 2'b10,
                  PRIO ? 32'hC0DE0001 : 32'hC0DE0002, 1);
    tick; drive_a(2'b11, 2'b00, 8'h01, 8'h02, 0, 0, 2'b01, 32'hC0DE0001, 1);
    tick; drive_a(2'b11, 2'b00, 8'h01, 8'h02, 0, 0, PRIO ? 2'b01 : 2'b10,
                  PRIO ? 32'hC0DE0001 : 32'hC0DE0002, 1);
    tick; drive_a(2'b00, 2'b00, 8'h00, 8'h00, 0, 0, 2'b00, 0, 1);
    // Single read on ch1
    tick; drive_a(2'b10, 2'b00, 8'h00, 8'h10, 0, 0, 2'b10, 32'hC0DE0010, 1);
    // ch1 loses, then changes its address before being granted
    tick; drive_a(2'b11, 2'b00, 8'h30, 8'h31, 0, 0, 2'b01, 32'hC0DE0030, 1);
    tick; drive_a(2'b10, 2'b00, 8'h30, 8'h32, 0, 0, 2'b10, 32'hC0DE0032, 1);
    // Write then read-back across channels
    tick; drive_a(2'b01, 2'b01, 8'h20, 8'h00, 32'hDEADBEEF, 0, 2'b01, 0, 1);
    tick; drive_a(2'b10, 2'b00, 8'h00, 8'h20, 0, 0, 2'b10, 32'hDEADBEEF, 1);
    // Read then write same address: read sees the old value, next read the new one
    tick; drive_a(2'b10, 2'b00, 8'h00, 8'h40, 0, 0, 2'b10, 32'hC0DE0040, 1);
    tick; drive_a(2'b01, 2'b01, 8'h40, 8'h00, 32'h12345678, 0, 2'b01, 0, 1);
    tick; drive_a(2'b10, 2'b00, 8'h00, 8'h40, 0, 0, 2'b10, 32'h12345678, 1);
    repeat (3) begin tick; drive_a(2'b00, 2'b00, 8'h00, 8'h00, 0, 0, 2'b00, 0, 1); end

    // Reset while a read is in flight
    tick; drive_a(2'b01, 2'b00, 8'h05, 8'h00, 0, 0, 2'b01, 0, 0);
    tick; rst = 1'b1; req_a = '0;
    @(negedge clk);
    check("midrst_mem_en_a", 64'(mem_en_a), 64'(0));
    check("midrst_rvalid_a", 64'(rvalid_a), 64'(0));
    tick; rst = 1'b0;
    @(negedge clk);
    check("postrst_rvalid_a", 64'(rvalid_a), 64'(0));
    tick; drive_a(2'b11, 2'b00, 8'h06, 8'h07, 0, 0, 2'b01, 32'hC0DE0006, 1);
    repeat (3) begin tick; drive_a(2'b00, 2'b00, 8'h00, 8'h00, 0, 0, 2'b00, 0, 1); end

    // Four channels, latency 2
    tick; drive_b(4'hF, 4'h1, 32'hC0DE0050);
    tick; drive_b(4'hF, PRIO ? 4'h1 : 4'h2, PRIO ? 32'hC0DE0050 : 32'hC0DE0051);
    tick; drive_b(4'hF, PRIO ? 4'h1 : 4'h4, PRIO ? 32'hC0DE0050 : 32'hC0DE0052);
    tick; drive_b(4'hF, PRIO ? 4'h1 : 4'h8, PRIO ? 32'hC0DE0050 : 32'hC0DE0053);
    tick; drive_b(4'h0, 4'h0, 0);
    repeat (6) tick;

    @(negedge clk);
    check("queues_drained", 64'(qg_a.size() + qm_a.size() + qr_a.size() + qg_b.size() + qr_b.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
